// File: rtl/ce_rate_bridge_pkg.sv
// Shared definitions for the clock-enable rate bridge: monitor states,
// default sizing and helpers that derive FIFO depth and gap-counter limit.
package ce_rate_bridge_pkg;

    localparam int unsigned DEFAULT_LOG2_DEPTH = 3;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } mon_state_e;

    // Number of FIFO entries for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned log2_depth);
        return 32'd1 << log2_depth;
    endfunction

    // Largest value the ce gap counter may hold before it sticks.
    function automatic int unsigned gap_limit(input int unsigned cnt_width);
        return (32'd1 << cnt_width) - 32'd1;
    endfunction

endpackage

// File: rtl/ce_bridge_fifo.sv
// Synchronous FIFO with registered occupancy; the head entry is always
// visible on rdata_o so a pop and its data are taken at the same edge.
module ce_bridge_fifo
    import ce_rate_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [LOG2_DEPTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned        DEPTH  = fifo_depth(LOG2_DEPTH);
    localparam logic [LOG2_DEPTH:0] FULL_C = (LOG2_DEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == FULL_C);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy moves only when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ce_rate_bridge.sv
// Full-rate stream in, one sample per ce pulse out, plus a monitor that
// checks ce arrives every PERIOD enabled cycles and reports lock/error.
module ce_rate_bridge
    import ce_rate_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH,
    parameter int PERIOD     = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  sysclk,
    input  logic                  sysclr,
    input  logic                  sysce,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [LOG2_DEPTH:0]   fill_level,
    output logic                  underflow,
    output logic                  ce_locked,
    output logic                  ce_err
);

    localparam logic [CNT_WIDTH-1:0] PER_C = CNT_WIDTH'(PERIOD);
    localparam logic [CNT_WIDTH-1:0] GMAX_C = CNT_WIDTH'(gap_limit(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    logic                  rd, pop, push;
    logic [DATA_WIDTH-1:0] head;
    logic                  fifo_full, fifo_empty;

    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q, underflow_q;

    mon_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  g_q, g_d;
    logic [1:0]            match_q, match_d;
    logic                  ce_err_q, ce_err_d;
    logic                  ce_locked_q;

    assign rd       = ce & sysce;
    assign pop      = rd & ~fifo_empty;
    assign s_tready = sysce & ~fifo_full;
    assign push     = s_tvalid & s_tready;

    ce_bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (sysclr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (s_tdata),
        .rdata_o (head),
        .count_o (fill_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output register: takes the FIFO head on each serviced ce, strobes once.
    always_ff @(posedge sysclk) begin
        if (sysclr) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            dout_valid_q <= pop;
            if (pop) dout_q <= head;
            if (rd && fifo_empty) underflow_q <= 1'b1;
        end
    end

    // Period monitor next state: gap check on ce, timeout when ce is overdue.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        match_d  = match_q;
        ce_err_d = ce_err_q;
        if (sysce) begin
            case (state_q)
                WAIT_FIRST: begin
                    if (ce) begin
                        state_d = TRACK;
                        g_d     = ONE_C;
                        match_d = 2'd0;
                    end
                end
                TRACK: begin
                    if (ce) begin
                        if (g_q == PER_C) begin
                            match_d = (match_q == 2'd2) ? 2'd2 : match_q + 2'd1;
                        end else begin
                            ce_err_d = 1'b1;
                            match_d  = 2'd0;
                        end
                        g_d = ONE_C;
                    end else begin
                        if (g_q == PER_C) begin
                            ce_err_d = 1'b1;
                            match_d  = 2'd0;
                        end
                        if (g_q != GMAX_C) g_d = g_q + ONE_C;
                    end
                end
                default: state_d = WAIT_FIRST;
            endcase
        end
    end

    // Period monitor state register; lock is registered from the next match.
    always_ff @(posedge sysclk) begin
        if (sysclr) begin
            state_q     <= WAIT_FIRST;
            g_q         <= '0;
            match_q     <= 2'd0;
            ce_err_q    <= 1'b0;
            ce_locked_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            match_q     <= match_d;
            ce_err_q    <= ce_err_d;
            ce_locked_q <= (match_d == 2'd2);
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign underflow  = underflow_q;
    assign ce_locked  = ce_locked_q;
    assign ce_err     = ce_err_q;

endmodule

// File: tb/tb_ce_rate_bridge.sv
// Bench for ce_rate_bridge: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue/timeline
// model of the bridge.
module tb_ce_rate_bridge;

    localparam int DW     = 16;
    localparam int L2D    = 3;
    localparam int DEPTH  = 8;
    localparam int PERIOD = 2;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          sysclr = 1'b1, sysce = 1'b0, ce = 1'b0, s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tready, dout_valid, underflow, ce_locked, ce_err;
    logic [DW-1:0] dout;
    logic [L2D:0]  fill_level;

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    ce_rate_bridge #(
        .DATA_WIDTH (DW),
        .LOG2_DEPTH (L2D),
        .PERIOD     (PERIOD),
        .CNT_WIDTH  (CW)
    ) dut (
        .sysclk     (clk),
        .sysclr     (sysclr),
        .sysce      (sysce),
        .ce         (ce),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .fill_level (fill_level),
        .underflow  (underflow),
        .ce_locked  (ce_locked),
        .ce_err     (ce_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_dv = 0, m_und = 0, m_err = 0;
    int            ce_t[$];   // enabled-cycle indices of the last three ce events
    int            k = 0;     // enabled cycles since reset

    function automatic bit m_locked();
        if (ce_t.size() < 3) return 0;
        if (ce_t[2] - ce_t[1] != PERIOD) return 0;
        if (ce_t[1] - ce_t[0] != PERIOD) return 0;
        return ((k - 1 - ce_t[2]) < PERIOD);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (sysclr) begin
                m_q.delete(); m_dout = '0; m_dv = 0; m_und = 0; m_err = 0;
                ce_t.delete(); k = 0;
            end else begin
                bit rd, wr;
                rd = ce && sysce;
                wr = s_tvalid && sysce && (m_q.size() < DEPTH);
                m_dv = 0;
                if (rd) begin
                    if (m_q.size() != 0) begin m_dout = m_q.pop_front(); m_dv = 1; end
                    else m_und = 1;
                end
                if (wr) m_q.push_back(s_tdata);
                if (sysce) begin
                    if (ce) begin
                        if (ce_t.size() > 0 && (k - ce_t[$]) != PERIOD) m_err = 1;
                        ce_t.push_back(k);
                        if (ce_t.size() > 3) void'(ce_t.pop_front());
                    end else if (ce_t.size() > 0 && (k - ce_t[$]) == PERIOD) begin
                        m_err = 1;
                    end
                    k++;
                end
            end
            #1;
            if (!done) begin
                chk("dout", dout, m_dout);
                chk("dout_valid", dout_valid, m_dv);
                chk("fill_level", fill_level, m_q.size());
                chk("underflow", underflow, m_und);
                chk("ce_err", ce_err, m_err);
                chk("ce_locked", ce_locked, m_locked());
                chk("s_tready", s_tready, sysce && (m_q.size() < DEPTH));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic clr, input logic sce, input logic c,
                       input logic v, input logic [DW-1:0] d);
        sysclr = clr; sysce = sce; ce = c; s_tvalid = v; s_tdata = d;
    endtask

    task automatic tick(input logic clr, input logic sce, input logic c,
                        input logic v, input logic [DW-1:0] d);
        drv(clr, sce, c, v, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, '0);
        tick(1, 1, 0, 0, '0);
    endtask

    initial begin
        int n, sc;
        @(negedge clk);
        do_reset();
        chk("rst_fill", fill_level, 0);
        chk("rst_dout", dout, 0);
        chk("rst_flags", {dout_valid, underflow, ce_locked, ce_err}, 4'b0000);

        // A: fill with 1..8, then drain one per ce every second cycle
        for (int i = 0; i < 8; i++) tick(0, 1, 0, 1, DW'(i + 1));
        chk("A_full_fill", fill_level, 8);
        chk("A_full_ready", s_tready, 0);
        n = 0;
        for (int j = 0; j < 16; j++) begin
            tick(0, 1, (j % 2 == 0), 0, '0);
            if (dout_valid) begin n++; chk("A_dout_seq", dout, n); end
            if (j == 2) chk("A_unlocked_2ce", ce_locked, 0);
            if (j == 4) chk("A_locked_3ce", ce_locked, 1);
        end
        chk("A_strobes", n, 8);
        chk("A_underflow", underflow, 0);
        chk("A_last_dout", dout, 16'h0008);

        // B: ce with nothing buffered
        do_reset();
        n = 0;
        for (int j = 0; j < 8; j++) begin
            tick(0, 1, (j % 2 == 0), 0, '0);
            if (j == 0) chk("B_underflow_first", underflow, 1);
            if (dout_valid) n++;
        end
        chk("B_no_strobe", n, 0);
        chk("B_dout_held", dout, 0);

        // C: ce gaps 2,2,3,2,2
        do_reset();
        begin
            bit pat[12] = '{1,0,1,0,1,0,0,1,0,1,0,1};
            for (int j = 0; j < 12; j++) begin
                tick(0, 1, pat[j], 0, '0);
                if (j == 4)  chk("C_lock", ce_locked, 1);
                if (j == 5)  chk("C_still_lock", ce_locked, 1);
                if (j == 6)  chk("C_timeout", {ce_locked, ce_err}, 2'b01);
                if (j == 9)  chk("C_one_gap", ce_locked, 0);
                if (j == 11) chk("C_relock", {ce_locked, ce_err}, 2'b11);
            end
        end

        // D: pop on full with a write offered in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) tick(0, 1, 0, 1, DW'(16'hD0 + i));
        drv(0, 1, 1, 1, 16'h0077);
        #1;
        chk("D_ready_full", s_tready, 0);
        chk("D_fill_8", fill_level, 8);
        @(negedge clk);
        chk("D_fill_7", fill_level, 7);
        chk("D_ready_again", s_tready, 1);
        chk("D_dout", dout, 16'h00D0);

        // E: sysce low for 5 cycles with ce high
        tick(0, 1, 0, 0, '0);
        for (int j = 0; j < 5; j++) begin
            tick(0, 0, 1, 1, 16'h00EE);
            chk("E_frozen_fill", fill_level, 7);
            chk("E_no_strobe", dout_valid, 0);
        end
        tick(0, 1, 1, 0, '0);
        chk("E_resume_pop", {dout_valid, dout}, {1'b1, 16'h00D1});
        chk("E_no_err", ce_err, 0);

        // F: reset while holding data and locked
        do_reset();
        tick(0, 1, 0, 1, 16'h0F00);
        tick(0, 1, 0, 1, 16'h0F01);
        for (int j = 0; j < 6; j++) tick(0, 1, (j % 2 == 0), 1, DW'(16'h0F02 + j));
        chk("F_pre_fill", fill_level, 5);
        chk("F_pre_lock", ce_locked, 1);
        tick(1, 1, 1, 1, 16'h0055);
        chk("F_fill", fill_level, 0);
        chk("F_dout", dout, 0);
        chk("F_lock_err", {ce_locked, ce_err}, 2'b00);
        for (int j = 0; j < 5; j++) tick(0, 1, 0, 0, '0);
        tick(0, 1, 1, 0, '0);
        chk("F_wait_first", ce_err, 0);
        tick(0, 1, 0, 0, '0); tick(0, 1, 1, 0, '0);
        tick(0, 1, 0, 0, '0); tick(0, 1, 1, 0, '0);
        chk("F_relock", {ce_locked, ce_err}, 2'b10);

        // Randomized traffic
        sc = 0;
        for (int j = 0; j < 3000; j++) begin
            logic c, se, cl, v;
            cl = ($urandom_range(0, 199) == 0);
            se = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 29) == 0) ? ~(sc % PERIOD == 0) : (sc % PERIOD == 0);
            v  = ($urandom_range(0, 2) != 0);
            if (se) sc++;
            tick(cl, se, c, v, DW'($urandom));
        end

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
